regfile_writeback: RTL and testbench
====================================

# regfile_writeback

Write-side front end for the 32x32 integer register file. It merges results from the single-cycle ALU path and the multi-cycle load/store unit (LSU) onto the file's single synchronous write port (w_en/rd/w_data), buffers LSU results in a small FIFO, and keeps a pending-write scoreboard so the issue stage can stall on RAW hazards against in-flight loads. It sits between execute/memory stages and the register file; its outputs drive the register file's write inputs directly.

## Interface
- LSU_DEPTH, 2: LSU result FIFO entries (power of two, 2..8).
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU result present this cycle; always accepted unless alu_stall.
- alu_rd  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- alu_stall  out  1  ALU must not present a result this cycle; combinational, = (FIFO count == LSU_DEPTH).
- lsu_valid  in  1  LSU result offered.
- lsu_ready  out  1  FIFO can accept; combinational, = (count != LSU_DEPTH).
- lsu_rd  in  5  LSU destination register.
- lsu_data  in  32  LSU result.
- issue_set  in  1  a long-latency (LSU) op targeting issue_rd is issued this cycle.
- issue_rd  in  5  destination of issued long-latency op.
- rs1, rs2  in  5  source registers of instruction in issue.
- rs1_busy, rs2_busy  out  1  combinational, = pending[rsX] & (rsX != 0).
- w_en  out  1  registered write enable to register file.
- rd  out  5  registered write address.
- w_data  out  32  registered write data.

## Operation
- LSU accept: lsu_valid & lsu_ready pushes {lsu_rd, lsu_data} into FIFO tail.
- Write-port arbitration each cycle, ALU priority:
  - alu_valid = 1: register {alu_rd, alu_data}; FIFO head not popped.
  - else FIFO non-empty: pop head, register its {rd, data}; clear pending[head rd].
  - else: w_en <= 0.
- Write suppression: selected rd == 0 -> w_en <= 0 (entry still consumed/popped); rd/w_data still updated.
- Push and pop in same cycle allowed; count unchanged. Push into full FIFO impossible (lsu_ready = 0). A newly pushed entry is not eligible for pop in its push cycle.
- Starvation guard: when FIFO full, alu_stall = 1; ALU contract: alu_valid = 0 that cycle, so head drains.
- alu_valid while alu_stall = 1 is a protocol violation; block ignores alu_valid that cycle and drains FIFO.
- Scoreboard: 32-bit pending vector.
  - issue_set & issue_rd != 0 -> pending[issue_rd] <= 1.
  - Clear on LSU pop as above (ALU writes never clear).
  - Same-cycle set and clear of same index: set wins.
  - Issue stage must not issue_set an rd whose busy is 1 (precondition; one outstanding load per rd).
- FIFO pointers wrap modulo LSU_DEPTH; count is separate, width clog2(LSU_DEPTH)+1.

## Timing
- Reset (async, immediate): w_en = 0, rd = 0, w_data = 0, FIFO empty (lsu_ready = 1, alu_stall = 0), pending = 0 (all busy = 0). Reset mid-operation discards FIFO contents and pending bits; no write issued afterward for them.
- ALU latency: alu_valid at edge N -> w_en = 1 during cycle N+1 (register file writes at edge N+1).
- LSU latency, uncontended: handshake at N -> pop at N+1 -> w_en during N+2; busy for that rd falls in cycle N+2.
- Busy deassert coincides with w_en for that rd; register file read of that rd is valid only from cycle after w_en (no bypass in this block).
- Throughput: one write per cycle; LSU sustains 1/cycle only when ALU idle.

## Test plan
- Reset: hold rst_n = 0 with random inputs -> w_en/rd/w_data = 0, lsu_ready = 1, alu_stall = 0, rs1_busy = rs2_busy = 0; release, all stay until stimulus.
- ALU path: alu_valid, rd = 5, data = 0xDEADBEEF at edge N -> w_en = 1, rd = 5, w_data = 0xDEADBEEF in N+1; alu_rd = 0 -> w_en = 0.
- Scoreboard: issue_set rd = 7 at N, rs1 = 7 -> rs1_busy = 1 from N+1; LSU result rd = 7, data = 0x12345678 at M -> w_en rd = 7 at M+2, rs1_busy = 0 in M+2; issue_rd = 0 never sets busy.
- Arbitration/full: LSU pushes rd 1,2 while ALU valid every cycle -> lsu_ready = 0, alu_stall = 1; drop alu_valid -> rd 1 then rd 2 written in order, lsu_ready returns 1 after first pop.
- Simultaneous: FIFO head rd = 9 pops same cycle issue_set rd = 9 -> pending[9] remains 1; push and pop same cycle with count = 1 -> count stays 1.
- Reset mid-flight: FIFO holding 2 entries, pending set, assert rst_n = 0 -> no subsequent w_en for those entries, busy cleared.

Source files
------------

// File: rtl/regfile_writeback.sv
// regfile_writeback
//   Write-side front end for the 32x32 integer register file. Merges the
//   single-cycle ALU result and the buffered LSU result stream onto the
//   file's one synchronous write port, and tracks in-flight long-latency
//   destinations so issue can stall on RAW hazards.
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   alu_valid/alu_rd/alu_data   ALU result (accepted whenever alu_stall = 0)
//   alu_stall                   FIFO full; ALU must hold off so the FIFO drains
//   lsu_valid/lsu_rd/lsu_data   LSU result offer
//   lsu_ready                   FIFO has room
//   issue_set/issue_rd          long-latency op issued towards issue_rd
//   rs1/rs2, rs1_busy/rs2_busy  hazard query for the instruction in issue
//   w_en/rd/w_data              registered register-file write port
module regfile_writeback #(
  parameter int LSU_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_stall,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  input  logic        issue_set,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic        w_en,
  output logic [4:0]  rd,
  output logic [31:0] w_data
);

  localparam int PW = $clog2(LSU_DEPTH);
  localparam int CW = $clog2(LSU_DEPTH) + 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_ent_t;

  wb_ent_t        fifo_q [LSU_DEPTH];
  logic [PW-1:0]  head_q, tail_q;
  logic [CW-1:0]  cnt_q;
  logic [31:0]    pending_q, pending_d;

  logic    full, empty;
  logic    alu_take, lsu_push, lsu_pop;
  wb_ent_t head_ent;

  assign full      = (cnt_q == CW'(LSU_DEPTH));
  assign empty     = (cnt_q == '0);
  assign alu_stall = full;
  assign lsu_ready = ~full;

  // A stalled ALU result is a protocol violation; ignoring it guarantees
  // the head drains and the ALU can never starve the LSU.
  assign alu_take = alu_valid & ~full;
  assign lsu_push = lsu_valid & ~full;
  // cnt_q is pre-push, so an entry pushed this cycle is never popped with it.
  assign lsu_pop  = ~alu_take & ~empty;
  assign head_ent = fifo_q[head_q];

  assign rs1_busy = pending_q[rs1] & (rs1 != 5'd0);
  assign rs2_busy = pending_q[rs2] & (rs2 != 5'd0);

  // Data array carries no reset: contents are qualified by cnt_q.
  always_ff @(posedge clk) begin
    if (lsu_push) fifo_q[tail_q] <= '{rd: lsu_rd, data: lsu_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (lsu_push) tail_q <= tail_q + PW'(1);
      if (lsu_pop)  head_q <= head_q + PW'(1);
      case ({lsu_push, lsu_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Set is applied after clear so a same-cycle set of the popped rd wins.
  always_comb begin
    pending_d = pending_q;
    if (lsu_pop) pending_d[head_ent.rd] = 1'b0;
    if (issue_set && issue_rd != 5'd0) pending_d[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  // Write port: ALU first, else FIFO head. rd 0 still updates rd/w_data
  // but never asserts w_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_en   <= 1'b0;
      rd     <= '0;
      w_data <= '0;
    end else if (alu_take) begin
      w_en   <= (alu_rd != 5'd0);
      rd     <= alu_rd;
      w_data <= alu_data;
    end else if (lsu_pop) begin
      w_en   <= (head_ent.rd != 5'd0);
      rd     <= head_ent.rd;
      w_data <= head_ent.data;
    end else begin
      w_en   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;
  localparam int D = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        alu_stall;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic [4:0]  lsu_rd = '0;
  logic [31:0] lsu_data = '0;
  logic        issue_set = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic [4:0]  rs1 = '0, rs2 = '0;
  logic        rs1_busy, rs2_busy;
  logic        w_en;
  logic [4:0]  rd;
  logic [31:0] w_data;

  regfile_writeback #(.LSU_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .issue_set(issue_set), .issue_rd(issue_rd),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .w_en(w_en), .rd(rd), .w_data(w_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  int   checks = 0;
  int   failures = 0;
  ent_t exp_q[$];   // register-file writes still expected, in order
  ent_t mq[$];      // reference LSU buffer
  bit [31:0] pend;  // reference set of in-flight destinations

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: every write the DUT presents must be the next expected one.
  always @(negedge clk) begin
    if (rst_n && w_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got rd=%0d data=0x%0h expected none at %0t", rd, w_data, $time);
      end else begin
        ent_t e;
        e = exp_q.pop_front();
        chk("write_rd", {59'd0, rd}, {59'd0, e.rd});
        chk("write_data", {32'd0, w_data}, {32'd0, e.data});
      end
    end
  end

  // Drive one cycle of inputs (called at posedge+1), check the combinational
  // outputs against the model, advance the model across the next edge, and
  // return at posedge+1 with the registered outputs of that edge visible.
  task automatic cycle(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                       input logic is, input logic [4:0] ird,
                       input logic [4:0] r1, input logic [4:0] r2);
    bit   full;
    ent_t e;
    alu_valid = av;  alu_rd = ard;  alu_data = adat;
    lsu_valid = lv;  lsu_rd = lrd;  lsu_data = ldat;
    issue_set = is;  issue_rd = ird;
    rs1 = r1;        rs2 = r2;
    #2;
    full = (mq.size() == D);
    chk("lsu_ready", {63'd0, lsu_ready}, {63'd0, !full});
    chk("alu_stall", {63'd0, alu_stall}, {63'd0, full});
    chk("rs1_busy", {63'd0, rs1_busy}, {63'd0, pend[r1] && r1 != 0});
    chk("rs2_busy", {63'd0, rs2_busy}, {63'd0, pend[r2] && r2 != 0});
    if (av && !full) begin
      if (ard != 0) exp_q.push_back('{ard, adat});
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      pend[e.rd] = 1'b0;
      if (e.rd != 0) exp_q.push_back(e);
    end
    if (lv && !full) mq.push_back('{lrd, ldat});
    if (is && ird != 0) pend[ird] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, r1, r2);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_w_en"}, {63'd0, w_en}, 64'd0);
    chk({tag, "_rd"}, {59'd0, rd}, 64'd0);
    chk({tag, "_w_data"}, {32'd0, w_data}, 64'd0);
    chk({tag, "_lsu_ready"}, {63'd0, lsu_ready}, 64'd1);
    chk({tag, "_alu_stall"}, {63'd0, alu_stall}, 64'd0);
    chk({tag, "_busy"}, {62'd0, rs1_busy, rs2_busy}, 64'd0);
  endtask

  initial begin
    pend = '0;
    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      alu_valid = 1'($urandom); alu_rd = 5'($urandom); alu_data = $urandom;
      lsu_valid = 1'($urandom); lsu_rd = 5'($urandom); lsu_data = $urandom;
      issue_set = 1'($urandom); issue_rd = 5'($urandom);
      rs1 = 5'($urandom); rs2 = 5'($urandom);
      #3;
      chk_reset_state("reset");
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3, 4);
    chk_reset_state("post_reset");

    // ALU path, and rd 0 suppression still updating rd/w_data
    cycle(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
    chk("alu_w_en", {63'd0, w_en}, 64'd1);
    chk("alu_rd", {59'd0, rd}, 64'd5);
    chk("alu_w_data", {32'd0, w_data}, 64'hDEADBEEF);
    cycle(1, 0, 32'hCAFEF00D, 0, 0, 0, 0, 0, 0, 0);
    chk("rd0_w_en", {63'd0, w_en}, 64'd0);
    chk("rd0_rd", {59'd0, rd}, 64'd0);
    chk("rd0_w_data", {32'd0, w_data}, 64'hCAFEF00D);

    // Scoreboard: busy from N+1, cleared together with the LSU write
    cycle(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    cycle(0, 0, 0, 1, 7, 32'h12345678, 0, 0, 7, 0);
    idle(7, 0);
    chk("ld_w_en", {63'd0, w_en}, 64'd1);
    chk("ld_rd", {59'd0, rd}, 64'd7);
    chk("ld_busy_clear", {63'd0, rs1_busy}, 64'd0);
    cycle(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(0, 0);

    // Arbitration / full FIFO
    cycle(1, 3, 32'h33, 1, 1, 32'h11, 0, 0, 0, 0);
    cycle(1, 4, 32'h44, 1, 2, 32'h22, 0, 0, 0, 0);
    chk("full_lsu_ready", {63'd0, lsu_ready}, 64'd0);
    chk("full_alu_stall", {63'd0, alu_stall}, 64'd1);
    cycle(1, 6, 32'h66, 0, 0, 0, 0, 0, 0, 0); // ignored while stalled
    chk("drain_ready", {63'd0, lsu_ready}, 64'd1);
    idle(0, 0);
    idle(0, 0);

    // Same-cycle clear and set of rd 9: set wins
    cycle(0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
    cycle(0, 0, 0, 1, 9, 32'h99, 0, 0, 9, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    chk("set_wins", {63'd0, rs1_busy}, 64'd1);
    cycle(0, 0, 0, 1, 9, 32'h999, 0, 0, 9, 9);
    idle(9, 9);
    idle(9, 9);

    // Push and pop with one entry held
    cycle(0, 0, 0, 1, 10, 32'hA0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 11, 32'hB0, 0, 0, 0, 0);
    idle(0, 0);
    idle(0, 0);

    // Reset mid-flight with two buffered loads and pending bits
    cycle(0, 0, 0, 0, 0, 0, 1, 12, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 13, 0, 0);
    cycle(1, 0, 0, 1, 12, 32'hC0, 0, 0, 12, 13);
    cycle(1, 0, 0, 1, 13, 32'hD0, 0, 0, 12, 13);
    chk("mid_full", {63'd0, alu_stall}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_w_en", {63'd0, w_en}, 64'd0);
    chk("mid_busy", {62'd0, rs1_busy, rs2_busy}, 64'd0);
    chk("mid_ready", {63'd0, lsu_ready}, 64'd1);
    mq.delete();
    exp_q.delete();
    pend = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) idle(12, 13);

    // Randomized traffic against the reference model
    for (int i = 0; i < 800; i++) begin
      logic av, lv, is;
      logic [4:0] ird;
      av  = ($urandom_range(0, 2) == 0);
      if (mq.size() == D && $urandom_range(0, 7) != 0) av = 1'b0;
      lv  = ($urandom_range(0, 1) == 0);
      ird = 5'($urandom_range(0, 15));
      is  = ($urandom_range(0, 3) == 0) && !pend[ird];
      cycle(av, 5'($urandom_range(0, 15)), $urandom, lv, 5'($urandom_range(0, 15)), $urandom,
            is, ird, 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
    end

    for (int i = 0; i < 10; i++) idle(0, 0);
    chk("drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
